// File: rtl/polar_frame_tx.sv
// polar_frame_tx: serialises {theta, r} polar results as UART-style frames
// (start, 8 data bits LSB first, optional even parity, stop) with a one-entry holding buffer.
module polar_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_r,
  input  logic [3:0] in_theta,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam bit PAR_ON = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t        state_r;
  logic [CW-1:0] baud_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic [7:0]    buf_r;
  logic          buf_full_r;
  logic          tx_r;
  logic          busy_r;
  logic          done_r;

  logic          accept_s;
  logic          baud_end_s;
  logic          stop_end_s;
  logic [7:0]    in_word_s;

  assign accept_s   = in_valid & ~buf_full_r;
  assign baud_end_s = (baud_r == BAUD_LAST);
  assign stop_end_s = (state_r == STOP) && baud_end_s;
  assign in_word_s  = {in_theta, in_r};

  assign in_ready   = ~buf_full_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

  // Frame sequencer: baud timing, bit selection and the registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_r <= '0;
          if (accept_s) begin
            shift_r <= in_word_s;
            state_r <= START;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (baud_end_s) begin
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= DATA;
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_end_s) begin
            baud_r <= '0;
            if (bit_idx_r != 3'd7) begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[bit_idx_r + 3'd1];
            end else if (PAR_ON) begin
              state_r <= PARITY;
              tx_r    <= even_parity(shift_r);
            end else begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        PARITY: begin
          if (baud_end_s) begin
            baud_r  <= '0;
            state_r <= STOP;
            tx_r    <= 1'b1;
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_end_s) begin
            baud_r <= '0;
            done_r <= 1'b1;
            // A buffered result has priority; a same-edge accept is only possible when it is empty.
            if (buf_full_r) begin
              shift_r <= buf_r;
              state_r <= START;
              tx_r    <= 1'b0;
            end else if (accept_s) begin
              shift_r <= in_word_s;
              state_r <= START;
              tx_r    <= 1'b0;
            end else begin
              state_r <= IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          baud_r  <= '0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry holding buffer for a result accepted while a frame is on the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_r <= 1'b0;
      buf_r      <= 8'h00;
    end else begin
      if (stop_end_s && buf_full_r) begin
        buf_full_r <= 1'b0;
      end else if (accept_s && (state_r != IDLE) && !stop_end_s) begin
        buf_r      <= in_word_s;
        buf_full_r <= 1'b1;
      end else begin
        buf_full_r <= buf_full_r;
      end
    end
  end

endmodule

// File: tb/tb_polar_frame_tx.sv
// tb_polar_frame_tx: two instances (parity on / off) compared every cycle against a
// queue-of-line-levels reference model, plus table vectors and hand-written corner sequences.
module tb_polar_frame_tx;
  localparam int CPB  = 4;
  localparam int LEN0 = 11 * CPB;
  localparam int LEN1 = 10 * CPB;
  localparam int QD   = 128;

  logic       clk;
  logic       rst;
  logic       valid [2];
  logic       rdy   [2];
  logic [3:0] rr    [2];
  logic [3:0] tt    [2];
  logic       txl   [2];
  logic       busy  [2];
  logic       done  [2];

  int checks;
  int errors;

  // Reference model: expected line level of every future cycle, queued per instance.
  logic mq_tx   [2][QD];
  logic mq_last [2][QD];
  int   mhead [2];
  int   mcnt  [2];
  logic m_tx [2], m_busy [2], m_done [2], m_rdy [2], m_last [2], acc [2];

  logic [8:0] got_q [$];

  polar_frame_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(valid[0]), .in_ready(rdy[0]), .in_r(rr[0]),
    .in_theta(tt[0]), .tx(txl[0]), .busy(busy[0]), .frame_done(done[0]));

  polar_frame_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_np (
    .clk(clk), .rst(rst), .in_valid(valid[1]), .in_ready(rdy[1]), .in_r(rr[1]),
    .in_theta(tt[1]), .tx(txl[1]), .busy(busy[1]), .frame_done(done[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic ref_parity(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; mcnt[k] = 0; m_tx[k] = 1'b1; m_busy[k] = 1'b0;
      m_done[k] = 1'b0; m_rdy[k] = 1'b1; m_last[k] = 1'b0; acc[k] = 1'b0;
    end
  endtask

  task automatic push_frame(input int k, input logic [7:0] d);
    int nb;
    nb = (k == 0) ? 11 : 10;
    for (int b = 0; b < nb; b++) begin
      logic v;
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else if (b == nb - 1) v = 1'b1;
      else v = ref_parity(d);
      for (int s = 0; s < CPB; s++) begin
        mq_tx[k][(mhead[k] + mcnt[k]) % QD]   = v;
        mq_last[k][(mhead[k] + mcnt[k]) % QD] = (b == nb - 1) && (s == CPB - 1);
        mcnt[k]++;
      end
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mhead[k] = 0; mcnt[k] = 0; m_tx[k] = 1'b1; m_busy[k] = 1'b0;
        m_done[k] = 1'b0; m_rdy[k] = 1'b1; m_last[k] = 1'b0; acc[k] = 1'b0;
      end else begin
        acc[k] = valid[k] && m_rdy[k];
        if (acc[k]) push_frame(k, {tt[k], rr[k]});
        m_done[k] = m_last[k];
        if (mcnt[k] > 0) begin
          m_tx[k]   = mq_tx[k][mhead[k]];
          m_last[k] = mq_last[k][mhead[k]];
          m_busy[k] = 1'b1;
          mhead[k]  = (mhead[k] + 1) % QD;
          mcnt[k]--;
        end else begin
          m_tx[k] = 1'b1; m_last[k] = 1'b0; m_busy[k] = 1'b0;
        end
        m_rdy[k] = mcnt[k] < ((k == 0) ? LEN0 : LEN1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("tx%0d", k), txl[k], m_tx[k]);
      check($sformatf("busy%0d", k), busy[k], m_busy[k]);
      check($sformatf("in_ready%0d", k), rdy[k], m_rdy[k]);
      check($sformatf("frame_done%0d", k), done[k], m_done[k]);
    end
  endtask

  task automatic offer(input int k, input logic [3:0] r, input logic [3:0] th);
    valid[k] = 1'b1; rr[k] = r; tt[k] = th;
  endtask

  // Asynchronous reset asserted between edges; outputs must react before any edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check({tag, "_tx"}, txl[k], 1'b1);
      check({tag, "_busy"}, busy[k], 1'b0);
      check({tag, "_in_ready"}, rdy[k], 1'b1);
      check({tag, "_frame_done"}, done[k], 1'b0);
    end
    model_clear();
    step();
    step();
    rst = 1'b0;
  endtask

  // Line monitor for the parity instance: decodes gap-free frames by cycle count.
  initial begin : mon_blk
    int cnt;
    logic active;
    logic [7:0] d;
    logic p;
    cnt = 0; active = 1'b0; d = 8'h00; p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0; cnt = 0;
      end else begin
        if (!active && txl[0] == 1'b0) begin
          active = 1'b1; cnt = 0;
        end
        if (active) begin
          if (cnt % CPB == CPB / 2) begin
            if (cnt / CPB >= 1 && cnt / CPB <= 8) d[cnt/CPB - 1] = txl[0];
            else if (cnt / CPB == 9) p = txl[0];
          end
          if (cnt == LEN0 - 1) begin
            got_q.push_back({p, d});
            active = 1'b0;
          end
          cnt++;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] r;
    logic [3:0] theta;
    logic [7:0] data;
    logic       par;
    int         done0;
    int         done1;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] wa, wb, wc;
    int n;
    tbl[0] = '{4'd5,  4'd9,  8'h95, 1'b0, 45, 41};
    tbl[1] = '{4'd7,  4'd0,  8'h07, 1'b1, 45, 41};
    tbl[2] = '{4'd0,  4'd0,  8'h00, 1'b0, 45, 41};
    tbl[3] = '{4'hF,  4'hF,  8'hFF, 1'b0, 45, 41};
    tbl[4] = '{4'd1,  4'd0,  8'h01, 1'b1, 45, 41};
    tbl[5] = '{4'hA,  4'h3,  8'h3A, 1'b0, 45, 41};
    tbl[6] = '{4'h2,  4'h6,  8'h62, 1'b1, 45, 41};
    tbl[7] = '{4'h8,  4'h0,  8'h08, 1'b1, 45, 41};

    checks = 0; errors = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin valid[k] = 1'b0; rr[k] = 4'h0; tt[k] = 4'h0; end
    model_clear();
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    pulse_reset("idle_rst");
    repeat (2) step();

    for (int v = 0; v < 8; v++) begin
      logic s0 [47];
      logic s1 [47];
      logic f0 [47];
      logic f1 [47];
      logic [7:0] g0, g1;
      int dc0, dc1;
      offer(0, tbl[v].r, tbl[v].theta);
      offer(1, tbl[v].r, tbl[v].theta);
      step();
      valid[0] = 1'b0; valid[1] = 1'b0;
      for (int c = 1; c <= 46; c++) begin
        if (c > 1) step();
        s0[c] = txl[0]; s1[c] = txl[1]; f0[c] = done[0]; f1[c] = done[1];
      end
      dc0 = 0; dc1 = 0;
      for (int c = 1; c <= 46; c++) begin
        if (f0[c] && dc0 == 0) dc0 = c;
        if (f1[c] && dc1 == 0) dc1 = c;
      end
      for (int i = 0; i < 8; i++) begin
        g0[i] = s0[(i + 1) * CPB + 2];
        g1[i] = s1[(i + 1) * CPB + 2];
      end
      check($sformatf("vec%0d_start_p", v), s0[2], 1'b0);
      check($sformatf("vec%0d_data_p", v), g0, tbl[v].data);
      check($sformatf("vec%0d_parity_p", v), s0[38], tbl[v].par);
      check($sformatf("vec%0d_stop_p", v), s0[42], 1'b1);
      check($sformatf("vec%0d_done_cycle_p", v), dc0, tbl[v].done0);
      check($sformatf("vec%0d_start_np", v), s1[2], 1'b0);
      check($sformatf("vec%0d_data_np", v), g1, tbl[v].data);
      check($sformatf("vec%0d_stop_np", v), s1[38], 1'b1);
      check($sformatf("vec%0d_idle_np", v), s1[42], 1'b1);
      check($sformatf("vec%0d_done_cycle_np", v), dc1, tbl[v].done1);
    end

    // Back-to-back: A sending, B buffered, C stalls until A's stop ends.
    wa = 8'hA1; wb = 8'h72; wc = 8'hC3;
    got_q.delete();
    offer(0, wa[3:0], wa[7:4]); step(); valid[0] = 1'b0;
    repeat (5) step();
    offer(0, wb[3:0], wb[7:4]); step();
    check("b2b_ready_low", rdy[0], 1'b0);
    offer(0, wc[3:0], wc[7:4]);
    n = 0;
    do begin step(); n++; end while (!acc[0] && n < 200);
    valid[0] = 1'b0;
    check("b2b_c_accept_wait", n, 39);
    check("b2b_b_start", txl[0], 1'b0);
    repeat (100) step();
    check("b2b_frames", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("b2b_a", got_q[0], {ref_parity(wa), wa});
      check("b2b_b", got_q[1], {ref_parity(wb), wb});
      check("b2b_c", got_q[2], {ref_parity(wc), wc});
    end

    // Reset during data bit 3 with the buffer full.
    got_q.delete();
    offer(0, 4'h4, 4'h5); step(); valid[0] = 1'b0;
    repeat (3) step();
    offer(0, 4'h6, 4'h7); step(); valid[0] = 1'b0;
    check("abort_buf_full", rdy[0], 1'b0);
    repeat (13) step();
    pulse_reset("abort_rst");
    repeat (60) step();
    check("abort_no_frame", got_q.size(), 0);
    offer(0, 4'h9, 4'hB); step(); valid[0] = 1'b0;
    repeat (50) step();
    check("abort_clean_frames", got_q.size(), 1);
    if (got_q.size() == 1) check("abort_clean", got_q[0], {ref_parity(8'hB9), 8'hB9});

    // Accept on the edge that ends STOP with the buffer empty.
    got_q.delete();
    offer(0, 4'h3, 4'h1); step(); valid[0] = 1'b0;
    repeat (43) step();
    check("same_edge_ready", rdy[0], 1'b1);
    offer(0, 4'hE, 4'h2); step(); valid[0] = 1'b0;
    check("same_edge_start", txl[0], 1'b0);
    check("same_edge_done", done[0], 1'b1);
    check("same_edge_busy", busy[0], 1'b1);
    repeat (50) step();
    check("same_edge_frames", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("same_edge_a", got_q[0], {ref_parity(8'h13), 8'h13});
      check("same_edge_b", got_q[1], {ref_parity(8'h2E), 8'h2E});
    end

    // Randomised traffic on both instances; upstream holds data until accepted.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!valid[k] && $urandom_range(0, 99) < 30) offer(k, 4'($urandom), 4'($urandom));
      end
      step();
      for (int k = 0; k < 2; k++) if (acc[k]) valid[k] = 1'b0;
    end
    valid[0] = 1'b0; valid[1] = 1'b0;
    repeat (100) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
